// File: rtl/mmio_uart_tx_responder_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and the bit-time helper.
package mmio_uart_tx_responder_pkg;

    localparam logic [3:0] TXDATA_OFS  = 4'h0;
    localparam logic [3:0] STATUS_OFS  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFS = 4'h8;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A divider of zero would stall the engine, so it behaves as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_responder_fifo.sv
// Synchronous byte FIFO feeding the UART engine; pushes into a full FIFO are
// refused and pops from an empty FIFO are ignored.
module mmio_uart_tx_responder_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx_responder.sv
// Memory-mapped UART transmitter: register window on the MEM-stage bus, TX FIFO
// and an 8N1 bit-serial engine driving the registered tx pin.
module mmio_uart_tx_responder
    import mmio_uart_tx_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit_s;
    logic [3:0]    ofs_s;
    logic          wr_txdata_s;
    logic          wr_status_s;
    logic          wr_baud_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [7:0]    fifo_dout_s;
    logic          pop_s;
    logic          busy_s;
    logic [15:0]   reload_s;
    logic [31:0]   status_s;
    logic [31:0]   rdata_s;
    logic          unused_bits_s;

    logic [15:0]   bauddiv_r;
    logic          ovf_r;
    tx_state_e     state_r, state_s;
    logic [15:0]   cnt_r, cnt_s;
    logic [2:0]    idx_r, idx_s;
    logic [7:0]    shreg_r, shreg_s;
    logic          tx_r, tx_s;

    assign hit_s         = (ALUResult[31:4] == BASE_ADDR[31:4]);
    assign ofs_s         = ALUResult[3:0];
    assign wr_txdata_s   = MemWrite & hit_s & (ofs_s == TXDATA_OFS);
    assign wr_status_s   = MemWrite & hit_s & (ofs_s == STATUS_OFS);
    assign wr_baud_s     = MemWrite & hit_s & (ofs_s == BAUDDIV_OFS);
    assign busy_s        = (state_r != S_IDLE);
    assign reload_s      = eff_div(bauddiv_r) - 16'd1;
    assign unused_bits_s = ^{funct3, WriteData[31:16]};

    mmio_uart_tx_responder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata_s),
        .din   (WriteData[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Divider register and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bauddiv_r <= DEFAULT_DIV;
            ovf_r     <= 1'b0;
        end else begin
            if (wr_baud_s) begin
                bauddiv_r <= WriteData[15:0];
            end
            if (wr_txdata_s && fifo_full_s) begin
                ovf_r <= 1'b1;
            end else if (wr_status_s && WriteData[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Load data mux; everything outside a hitting load reads as zero.
    always_comb begin
        status_s = 32'h0;
        status_s[7:4]      = 4'(fifo_count_s);
        status_s[ST_OVF]   = ovf_r;
        status_s[ST_EMPTY] = fifo_empty_s;
        status_s[ST_FULL]  = fifo_full_s;
        status_s[ST_BUSY]  = busy_s;
        rdata_s = 32'h0;
        if (MemRead && hit_s) begin
            case (ofs_s)
                STATUS_OFS:  rdata_s = status_s;
                BAUDDIV_OFS: rdata_s = {16'h0, bauddiv_r};
                default:     rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    // Engine next state. The divider is only sampled when a bit starts, so a
    // BAUDDIV write mid-bit takes effect at the following bit boundary.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shreg_s = shreg_r;
        tx_s    = tx_r;
        pop_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shreg_s = fifo_dout_s;
                    tx_s    = 1'b0;
                    cnt_s   = reload_s;
                    state_s = S_START;
                end else begin
                    tx_s = 1'b1;
                end
            end
            S_START: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    idx_s   = 3'd0;
                    tx_s    = shreg_r[0];
                    cnt_s   = reload_s;
                    state_s = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else if (idx_r == 3'd7) begin
                    tx_s    = 1'b1;
                    cnt_s   = reload_s;
                    state_s = S_STOP;
                end else begin
                    idx_s   = idx_r + 3'd1;
                    shreg_s = {1'b0, shreg_r[7:1]};
                    tx_s    = shreg_r[1];
                    cnt_s   = reload_s;
                end
            end
            S_STOP: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else if (!fifo_empty_s) begin
                    // Back-to-back frame: next start bit follows the stop bit directly.
                    pop_s   = 1'b1;
                    shreg_s = fifo_dout_s;
                    tx_s    = 1'b0;
                    cnt_s   = reload_s;
                    state_s = S_START;
                end else begin
                    tx_s    = 1'b1;
                    state_s = S_IDLE;
                end
            end
            default: begin
                tx_s    = 1'b1;
                state_s = S_IDLE;
            end
        endcase
    end

    // Engine state registers; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shreg_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            tx_r    <= tx_s;
        end
    end

    assign ReadData = rdata_s;
    assign tx       = tx_r;
    assign irq      = fifo_empty_s & ~busy_s;

endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// Directed and randomized bench for mmio_uart_tx_responder: expected line
// waveforms come from the 8N1 frame rule, received bytes from a line decoder.
module tb_mmio_uart_tx_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_BD = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int mon_div = 868;
    logic [7:0] rx_q[$];

    mmio_uart_tx_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        funct3    = 3'($urandom_range(0, 7));
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        MemRead   = 1'b1;
        ALUResult = a;
        #1;
        d = ReadData;
        MemRead = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_div(input int d);
        wr(A_BD, 32'(d));
        mon_div = d;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[i];
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(irq), 32'd1);
    endtask

    // Called at the sample where the first start bit is already on the line.
    task automatic check_wave(input logic [7:0] b0, input logic [7:0] b1,
                              input int nbytes, input int div, input int probe_k);
        int flen = 10 * div;
        for (int k = 0; k < nbytes * flen; k++) begin
            logic [7:0] b;
            b = (k / flen == 0) ? b0 : b1;
            chk("tx_wave", 32'(tx), 32'(frame_bit(b, (k % flen) / div)));
            if (k == probe_k) begin
                MemRead   = 1'b1;
                ALUResult = A_ST;
                #1;
                chk("mid_frame_status", ReadData, 32'h5);
                MemRead = 1'b0;
            end
            @(negedge clk);
        end
        chk("wave_end_tx", 32'(tx), 32'd1);
        chk("wave_end_irq", 32'(irq), 32'd1);
    endtask

    // Line decoder: samples each bit in its middle at the current divider.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (mon_div) @(negedge clk);
                    b[j] = tx;
                end
                repeat (mon_div) @(negedge clk);
                if (tx === 1'b1) rx_q.push_back(b);
            end
        end
    end

    initial begin : stim
        logic [31:0] r;
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        int          d;
        int          n;
        int          zeros;

        repeat (3) @(negedge clk);
        chk("in_reset_tx", 32'(tx), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        rd(A_ST, r);  chk("reset_status", r, 32'h4);
        rd(A_BD, r);  chk("reset_baud", r, 32'd868);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd1);
        ALUResult = A_ST;
        #1;
        chk("no_read_zero", ReadData, 32'h0);
        @(negedge clk);

        // Single frame at DIV=4.
        set_div(4);
        wr(A_TX, 32'h55);
        chk("irq_busy", 32'(irq), 32'd0);
        @(negedge clk);
        check_wave(8'h55, 8'h00, 1, 4, 20);

        // Two queued frames at DIV=3, no idle gap.
        set_div(3);
        wr(A_TX, 32'hA5);
        wr(A_TX, 32'h3C);
        check_wave(8'hA5, 8'h3C, 2, 3, 45);

        // Randomized bursts that fit in the FIFO.
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(1, 4);
            n = $urandom_range(1, 8);
            set_div(d);
            rx_q.delete();
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                wr(A_TX, {24'h0, b});
            end
            wait_idle(10 * d * n + 20);
            chk("rand_count", 32'(rx_q.size()), 32'(n));
            for (int i = 0; i < n && i < rx_q.size(); i++) chk("rand_byte", {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
            rd(A_ST, r);  chk("rand_status", r, 32'h4);
        end

        // Fill, overflow and clear at DIV=2.
        set_div(2);
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wr(A_TX, {24'h0, b});
        end
        rd(A_ST, r);  chk("full_status", r, 32'h83);
        for (int i = 0; i < 10; i++) wr(A_TX, 32'($urandom));
        rd(A_ST, r);  chk("ovf_status", r, 32'h8B);
        wr(A_ST, 32'h8);
        rd(A_ST, r);
        chk("ovf_cleared", 32'(r[3]), 32'd0);
        chk("busy_after_clear", 32'(r[0]), 32'd1);
        wait_idle(9 * 20 + 40);
        chk("ovf_rx_count", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) chk("ovf_rx_byte", {24'h0, rx_q[i]}, {24'h0, exp_q[i]});

        // BAUDDIV rewritten mid DATA bit 2 of a DIV=4 frame.
        set_div(4);
        b = 8'($urandom);
        wr(A_TX, {24'h0, b});
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            chk("div_change_wave", 32'(tx), 32'(frame_bit(b, (k < 16) ? k / 4 : 4 + (k - 16) / 8)));
            if (k == 13) begin
                MemWrite  = 1'b1;
                ALUResult = A_BD;
                WriteData = 32'd8;
            end
            @(negedge clk);
            MemWrite = 1'b0;
        end
        chk("div_change_end_tx", 32'(tx), 32'd1);
        chk("div_change_end_irq", 32'(irq), 32'd1);
        mon_div = 8;
        rd(A_BD, r);  chk("div_change_baud", r, 32'd8);

        // Reset mid frame.
        set_div(4);
        wr(A_TX, 32'h00);
        wr(A_TX, 32'hFF);
        repeat (10) @(negedge clk);
        chk("pre_reset_tx", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        chk("async_reset_tx", 32'(tx), 32'd1);
        chk("async_reset_irq", 32'(irq), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd(A_ST, r);  chk("post_reset_status", r, 32'h4);
        rd(A_BD, r);  chk("post_reset_baud", r, 32'd868);
        zeros = 0;
        for (int k = 0; k < 30; k++) begin
            if (tx !== 1'b1) zeros++;
            @(negedge clk);
        end
        chk("fifo_discarded", 32'(zeros), 32'd0);

        // Accesses outside the window.
        rd(BASE + 32'h100, r);  chk("miss_read", r, 32'h0);
        rd(BASE + 32'h104, r);  chk("miss_status_alias", r, 32'h0);
        rd(BASE + 32'hC, r);    chk("reserved_read", r, 32'h0);
        wr(BASE + 32'h100, 32'h5A);
        wr(BASE + 32'h108, 32'd5);
        repeat (3) @(negedge clk);
        chk("miss_write_tx", 32'(tx), 32'd1);
        rd(A_ST, r);  chk("miss_write_status", r, 32'h4);
        rd(A_BD, r);  chk("miss_write_baud", r, 32'd868);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
